// File: rtl/math_axi_lite_slave.sv
// AXI4-Lite register slave fronting an iterative 32x32 shift-add multiplier.
// Define MATH_AXI_IRQ_EN to add the irq output and the CTRL.IRQ_ENABLE bit.
module math_axi_lite_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
`ifdef MATH_AXI_IRQ_EN
  ,
  output logic                            irq
`endif
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t state_q, state_d;

  logic          awready_q;
  logic          wready_q;
  logic          bvalid_q;
  logic          arready_q;
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;

  logic [DW-1:0] op_a_q;
  logic [DW-1:0] op_b_q;
  logic [DW-1:0] scratch_q;
  logic [DW-1:0] res_lo_q;
  logic [DW-1:0] res_hi_q;
  logic          done_q;

  logic [2*DW-1:0] mcand_q;
  logic [2*DW-1:0] acc_q;
  logic [2*DW-1:0] acc_next;
  logic [DW-1:0]   mplier_q;
  logic [4:0]      count_q;

  logic          wr_en;
  logic          rd_en;
  logic [2:0]    wr_idx;
  logic [2:0]    rd_idx;
  logic          busy;
  logic          start_go;
  logic          done_set;
  logic          done_clr;
  logic [DW-1:0] ctrl_rd;
  logic [DW-1:0] rd_mux;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0] old_v,
    input logic [DW-1:0] new_v,
    input logic [SW-1:0] strb
  );
    logic [DW-1:0] v;
    v = old_v;
    for (int i = 0; i < SW; i++) begin
      if (strb[i]) v[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return v;
  endfunction

  assign wr_en  = awready_q & wready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en  = arready_q & S_AXI_ARVALID;
  assign wr_idx = S_AXI_AWADDR[4:2];
  assign rd_idx = S_AXI_ARADDR[4:2];
  assign busy   = (state_q == S_RUN);

  assign start_go = wr_en & (wr_idx == 3'd2) & S_AXI_WSTRB[0]
                  & S_AXI_WDATA[0] & ~busy;
  assign done_set = busy & (count_q == 5'd31);
  assign done_clr = wr_en & (wr_idx == 3'd3) & S_AXI_WSTRB[0]
                  & S_AXI_WDATA[1];

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      awready_q <= S_AXI_AWVALID & S_AXI_WVALID
                 & ~bvalid_q & ~awready_q;
      wready_q  <= S_AXI_AWVALID & S_AXI_WVALID
                 & ~bvalid_q & ~awready_q;
      if (wr_en) begin
        bvalid_q <= 1'b1;
      end else if (S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      arready_q <= S_AXI_ARVALID & ~rvalid_q & ~arready_q;
      // Capture uses pre-edge register values, so a colliding write is not seen
      if (rd_en) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

`ifdef MATH_AXI_IRQ_EN
  logic irq_en_q;
  logic irq_q;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_en && wr_idx == 3'd2 && S_AXI_WSTRB[0]) begin
        irq_en_q <= S_AXI_WDATA[1];
      end
      irq_q <= done_q & irq_en_q;
    end
  end

  assign irq     = irq_q;
  assign ctrl_rd = {{(DW-2){1'b0}}, irq_en_q, 1'b0};
`else
  assign ctrl_rd = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      3'd0:    rd_mux = op_a_q;
      3'd1:    rd_mux = op_b_q;
      3'd2:    rd_mux = ctrl_rd;
      3'd3:    rd_mux = {{(DW-2){1'b0}}, done_q, busy};
      3'd4:    rd_mux = res_lo_q;
      3'd5:    rd_mux = res_hi_q;
      3'd6:    rd_mux = scratch_q;
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_go) state_d = S_RUN;
      S_RUN:   if (count_q == 5'd31) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      scratch_q <= '0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
      done_q    <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
    end else begin
      if (wr_en && wr_idx == 3'd0) begin
        op_a_q <= merge(op_a_q, S_AXI_WDATA, S_AXI_WSTRB);
      end
      if (wr_en && wr_idx == 3'd1) begin
        op_b_q <= merge(op_b_q, S_AXI_WDATA, S_AXI_WSTRB);
      end
      if (wr_en && wr_idx == 3'd6) begin
        scratch_q <= merge(scratch_q, S_AXI_WDATA, S_AXI_WSTRB);
      end
      // Operands are snapshotted so later register writes leave the run intact
      if (start_go) begin
        mcand_q  <= {{DW{1'b0}}, op_a_q};
        mplier_q <= op_b_q;
        acc_q    <= '0;
        count_q  <= '0;
      end else if (busy) begin
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        acc_q    <= acc_next;
        count_q  <= count_q + 5'd1;
      end
      if (done_set) begin
        res_lo_q <= acc_next[DW-1:0];
        res_hi_q <= acc_next[2*DW-1:DW];
      end
      if (done_set) begin
        done_q <= 1'b1;
      end else if (done_clr) begin
        done_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_math_axi_lite_slave.sv
// Directed bench for math_axi_lite_slave: register table plus timed sequences.
// Build with MATH_AXI_IRQ_EN defined to also exercise the irq path.
module tb_math_axi_lite_slave;

  localparam logic [4:0] A_OPA  = 5'h00;
  localparam logic [4:0] A_OPB  = 5'h04;
  localparam logic [4:0] A_CTRL = 5'h08;
  localparam logic [4:0] A_STAT = 5'h0C;
  localparam logic [4:0] A_RLO  = 5'h10;
  localparam logic [4:0] A_RHI  = 5'h14;
  localparam logic [4:0] A_SCR  = 5'h18;
  localparam logic [4:0] A_RSV  = 5'h1C;

  logic        tb_ACLK;
  logic        areset;
  logic [4:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
`ifdef MATH_AXI_IRQ_EN
  logic        irq;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int wr_cyc = 0;
  int st     = 0;
  int n_cnt  = 0;
  logic [31:0] rd_d;
  logic [1:0]  rd_r;
  logic [1:0]  wr_r;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  math_axi_lite_slave dut (
    .S_AXI_ACLK   (tb_ACLK),
    .S_AXI_ARESET (areset),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWPROT (awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARPROT (arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready)
`ifdef MATH_AXI_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  initial begin
    tb_ACLK = 1'b0;
    forever #5 tb_ACLK = ~tb_ACLK;
  end

  always @(posedge tb_ACLK) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for handshake", nm);
  endtask

  // Called at a negedge; returns at a negedge with BVALID already retired.
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    int n;
    awaddr = a;
    wdata  = d;
    wstrb  = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin
      @(negedge tb_ACLK);
      n++;
    end
    if (n >= 20) tmo("awready");
    @(negedge tb_ACLK);
    wr_cyc  = cyc;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge tb_ACLK);
      n++;
    end
    if (n >= 20) tmo("bvalid");
    resp = bresp;
    @(negedge tb_ACLK);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    int n;
    araddr  = a;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge tb_ACLK);
      n++;
    end
    if (n >= 20) tmo("arready");
    @(negedge tb_ACLK);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin
      @(negedge tb_ACLK);
      n++;
    end
    if (n >= 20) tmo("rvalid");
    d    = rdata;
    resp = rresp;
    @(negedge tb_ACLK);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    axi_write(a, d, 4'hF, wr_r);
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] a,
                        input logic [31:0] exp);
    axi_read(a, rd_d, rd_r);
    check(nm, rd_d, exp);
  endtask

  // Read whose RDATA capture edge is absolute edge number tgt.
  task automatic read_at(input string nm, input logic [4:0] a,
                         input int tgt, input logic [31:0] exp);
    while (cyc + 2 < tgt) @(negedge tb_ACLK);
    rd_chk(nm, a, exp);
  endtask

  // Write whose register-update edge is absolute edge number tgt.
  task automatic write_at(input logic [4:0] a, input logic [31:0] d,
                          input int tgt);
    while (cyc + 2 < tgt) @(negedge tb_ACLK);
    wr(a, d);
  endtask

  initial begin
    vecs[0]  = '{A_OPA,  32'h0101FFFF, 4'hF, 32'h0101FFFF};
    vecs[1]  = '{A_OPB,  32'hABCD0001, 4'hF, 32'hABCD0001};
    vecs[2]  = '{A_SCR,  32'hDEAD0011, 4'hF, 32'hDEAD0011};
    vecs[3]  = '{A_OPA,  32'hBEEF0011, 4'hF, 32'hBEEF0011};
    vecs[4]  = '{A_SCR,  32'h0101FFFF, 4'hF, 32'h0101FFFF};
    vecs[5]  = '{A_SCR,  32'hAABBCCDD, 4'h3, 32'h0101CCDD};
    vecs[6]  = '{A_RLO,  32'h12345678, 4'hF, 32'h00000000};
    vecs[7]  = '{A_RHI,  32'h12345678, 4'hF, 32'h00000000};
    vecs[8]  = '{A_CTRL, 32'hFFFFFFFC, 4'hF, 32'h00000000};
    vecs[9]  = '{A_RSV,  32'hFFFFFFFF, 4'hF, 32'h00000000};
    vecs[10] = '{A_STAT, 32'hFFFFFFFC, 4'hF, 32'h00000000};
    vecs[11] = '{A_OPB,  32'h11223344, 4'hC, 32'h11220001};
    vecs[12] = '{A_OPA,  32'hFFFFFFFF, 4'h0, 32'hBEEF0011};

    areset  = 1'b1;
    awaddr  = '0;
    awprot  = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wvalid  = 1'b0;
    bready  = 1'b1;
    araddr  = '0;
    arprot  = '0;
    arvalid = 1'b0;
    rready  = 1'b1;
    repeat (3) @(negedge tb_ACLK);
    areset = 1'b0;

    check("reset_hs", {awready, wready, bvalid, arready, rvalid}, 0);
    check("reset_rdata", rdata, 0);
`ifdef MATH_AXI_IRQ_EN
    check("reset_irq", irq, 0);
`endif
    rd_chk("reset_status", A_STAT, 0);

    for (int i = 0; i < NV; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, wr_r);
      check($sformatf("v%0d_bresp", i), wr_r, 0);
      axi_read(vecs[i].addr, rd_d, rd_r);
      check($sformatf("v%0d_rresp", i), rd_r, 0);
      check($sformatf("v%0d_data", i), rd_d, vecs[i].exp);
    end

    // AW three cycles ahead of W, then BREADY held low for five cycles
    awaddr  = A_SCR;
    wdata   = 32'h5A5A1234;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    bready  = 1'b0;
    n_cnt = 0;
    repeat (3) begin
      @(negedge tb_ACLK);
      if (awready || wready) n_cnt++;
    end
    check("aw_only_wait", n_cnt, 0);
    wvalid = 1'b1;
    @(negedge tb_ACLK);
    check("aw_w_pulse", {awready, wready}, 2'b11);
    @(negedge tb_ACLK);
    check("b_rise", {bvalid, awready, wready}, 3'b100);
    n_cnt = 0;
    repeat (5) begin
      @(negedge tb_ACLK);
      if (bvalid && !awready && !wready && bresp == 2'b00) n_cnt++;
    end
    check("b_hold", n_cnt, 5);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b1;
    @(negedge tb_ACLK);
    check("b_drop", bvalid, 0);
    rd_chk("aw_first_data", A_SCR, 32'h5A5A1234);

    // Write and read of SCRATCH accepted on the same edge
    awaddr  = A_SCR;
    wdata   = 32'hC0FFEE00;
    wstrb   = 4'hF;
    araddr  = A_SCR;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    arvalid = 1'b1;
    @(negedge tb_ACLK);
    check("same_ready", {awready, wready, arready}, 3'b111);
    @(negedge tb_ACLK);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    arvalid = 1'b0;
    check("same_valid", {bvalid, rvalid}, 2'b11);
    check("same_old_data", rdata, 32'h5A5A1234);
    @(negedge tb_ACLK);
    rd_chk("same_new_data", A_SCR, 32'hC0FFEE00);

    // Run 1: 0xFFFF * 0x10001
    wr(A_OPA, 32'h0000FFFF);
    wr(A_OPB, 32'h00010001);
    wr(A_CTRL, 32'h1);
    st = wr_cyc;
    rd_chk("run1_busy_early", A_STAT, 32'h1);
    read_at("run1_busy_last", A_STAT, st + 32, 32'h1);
    rd_chk("run1_done", A_STAT, 32'h2);
    rd_chk("run1_res_lo", A_RLO, 32'hFFFFFFFF);
    rd_chk("run1_res_hi", A_RHI, 32'h00000000);
    rd_chk("ctrl_self_clear", A_CTRL, 32'h0);
    wr(A_STAT, 32'h2);
    rd_chk("done_w1c", A_STAT, 32'h0);

    // Run 2: max operands with START and OP_A writes during the run
    wr(A_OPA, 32'hFFFFFFFF);
    wr(A_OPB, 32'hFFFFFFFF);
    wr(A_CTRL, 32'h1);
    st = wr_cyc;
    wr(A_CTRL, 32'h1);
    wr(A_OPA, 32'h0);
    read_at("run2_idle_edge", A_STAT, st + 33, 32'h2);
    repeat (40) @(negedge tb_ACLK);
    rd_chk("run2_no_restart", A_STAT, 32'h2);
    rd_chk("run2_res_hi", A_RHI, 32'hFFFFFFFE);
    rd_chk("run2_res_lo", A_RLO, 32'h00000001);
    rd_chk("run2_op_a", A_OPA, 32'h0);

    // Run 3: W1C of DONE lands on the completion edge
    wr(A_STAT, 32'h2);
    wr(A_OPA, 32'd7);
    wr(A_OPB, 32'd6);
    wr(A_CTRL, 32'h1);
    st = wr_cyc;
    write_at(A_STAT, 32'h2, st + 32);
    check("w1c_edge_at", wr_cyc, st + 32);
    rd_chk("set_beats_clear", A_STAT, 32'h2);
    rd_chk("run3_res_lo", A_RLO, 32'd42);

    // Reset with the multiplier at count 10
    wr(A_SCR, 32'h13579BDF);
    wr(A_OPA, 32'd3);
    wr(A_OPB, 32'd4);
    wr(A_CTRL, 32'h1);
    st = wr_cyc;
    while (cyc < st + 10) @(negedge tb_ACLK);
    areset = 1'b1;
    @(negedge tb_ACLK);
    areset = 1'b0;
    rd_chk("rst_status", A_STAT, 32'h0);
    rd_chk("rst_op_a", A_OPA, 32'h0);
    rd_chk("rst_op_b", A_OPB, 32'h0);
    rd_chk("rst_scratch", A_SCR, 32'h0);
    rd_chk("rst_res_lo", A_RLO, 32'h0);
    rd_chk("rst_res_hi", A_RHI, 32'h0);
    repeat (40) @(negedge tb_ACLK);
    rd_chk("rst_no_done", A_STAT, 32'h0);

`ifdef MATH_AXI_IRQ_EN
    wr(A_CTRL, 32'h2);
    rd_chk("irq_en_rd", A_CTRL, 32'h2);
    wr(A_OPA, 32'd3);
    wr(A_OPB, 32'd5);
    wr(A_CTRL, 32'h3);
    st = wr_cyc;
    while (cyc < st + 32) @(negedge tb_ACLK);
    check("irq_lags_done", irq, 0);
    @(negedge tb_ACLK);
    check("irq_set", irq, 1);
    wr(A_STAT, 32'h2);
    check("irq_clear", irq, 0);
    rd_chk("irq_res_lo", A_RLO, 32'd15);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/math_axi_lite_slave.md
Name: math_axi_lite_slave

Overview:
AXI4-Lite responder (slave) for the math peripheral. It is the other end of the AXI4-Lite master BFM that drives write/read bursts in the block-design bench. It exposes eight 32-bit registers: operands, control, status, a 64-bit result and a scratch register. Behind them sits an iterative 32x32 unsigned shift-add multiplier started by a register write.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word registers, decoded on addr[4:2].

Ports:
S_AXI_ACLK  in  1  single clock for all logic.
S_AXI_ARESET  in  1  reset; synchronous to S_AXI_ACLK, active-high.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte strobes.
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
S_AXI_BRESP  out  2  always 2'b00 (OKAY).
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  always 2'b00.
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.

Behaviour:
- Reset (S_AXI_ARESET=1 at a clock edge) clears:
  - all READY/VALID outputs to 0; RDATA to 0;
  - all registers to 0; FSM to IDLE.
  - Reset mid-multiply aborts the operation; DONE stays 0.
- Write channel:
  - When AWVALID & WVALID & !BVALID & !AWREADY, assert AWREADY and WREADY together for exactly one cycle. The register write happens on that edge.
  - BVALID rises the next cycle and holds until BREADY; then it drops.
  - AW without W, or W without AW, is not accepted; the slave waits for both.
- Read channel:
  - When ARVALID & !RVALID & !ARREADY, ARREADY pulses one cycle.
  - RDATA is captured and RVALID rises the next cycle; RVALID holds until RREADY.
  - RDATA is stable while RVALID=1.
- Same-cycle write and read to the same register: the read returns the pre-write value.
- Register map (word index, access):
  - 0 OP_A, R/W.
  - 1 OP_B, R/W.
  - 2 CTRL, write bit0=START (self-clearing, reads 0); other bits read 0.
  - 3 STATUS, bit0 BUSY (RO), bit1 DONE (sticky; write 1 to bit1 clears it).
  - 4 RES_LO, RO.
  - 5 RES_HI, RO.
  - 6 SCRATCH, R/W.
  - 7 reads 0.
  - Writes to RO/reserved registers are dropped, still with OKAY.
- WSTRB applies per byte to R/W registers. CTRL/STATUS act only if WSTRB[0]=1.
- FSM IDLE / RUN:
  - IDLE -> RUN on the edge after START written with BUSY=0.
  - On entry, OP_A and OP_B are snapshotted; product accumulator and count are cleared to 0.
  - RUN: one shift-add step per cycle; count 0..31.
  - On the step with count=31: go to IDLE; RES_LO/RES_HI take the 64-bit product; DONE=1.
  - BUSY=1 for exactly 32 cycles after the START write edge.
- START while BUSY=1 is ignored.
- OP_A/OP_B writes during RUN update the registers but not the in-flight product.
- RES_LO/RES_HI keep the last result until the next completion.
- DONE set and W1C on the same edge: set wins.

Optional Feature:
Macro MATH_AXI_IRQ_EN.
- Defined: adds output port irq (1 bit, reset 0) and CTRL bit1 IRQ_ENABLE (R/W, reset 0). irq = DONE & IRQ_ENABLE, registered, so it follows DONE by one cycle.
- Undefined: no irq port exists and CTRL bit1 reads 0.

Test Plan:
- Write 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 to OP_A, OP_B, SCRATCH, OP_A in turn -> each read-back equals the written value; BRESP and RRESP are 0x0.
- OP_A=0x0000FFFF, OP_B=0x00010001, write CTRL=1 -> BUSY reads 1 for 32 cycles, then DONE=1; RES_LO=0xFFFFFFFF, RES_HI=0x00000000.
- OP_A=OP_B=0xFFFFFFFF, START; a second START and OP_A=0 are written mid-run -> RES_HI=0xFFFFFFFE, RES_LO=0x00000001; no second operation starts.
- SCRATCH=0x0101FFFF, then write 0xAABBCCDD with WSTRB=4'b0011 -> reads 0x0101CCDD. A write of 0x12345678 to RES_LO -> RES_LO is unchanged; BRESP is 0x0.
- Assert AWVALID 3 cycles before WVALID; hold BREADY low 5 cycles -> AWREADY/WREADY pulse once only after WVALID; BVALID is held steady until BREADY.
- START, then ARESET=1 for one cycle at count=10 -> BUSY=0, DONE=0, all registers 0. With MATH_AXI_IRQ_EN and IRQ_ENABLE=1, a completed run -> irq=1 one cycle after DONE; writing STATUS bit1=1 drops irq.
